// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Parametrised UART receiver (5..9 data bits, none/odd/even parity,
//            1 or 2 stop bits) with start-glitch rejection, parity / framing /
//            break / overrun status and a valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 i_SysClock,
  input  logic                 i_Reset,
  input  logic                 i_RxSerial,
  output logic [DATA_BITS-1:0] o_RxData,
  output logic                 o_RxValid,
  input  logic                 i_RxReady,
  output logic                 o_ParityErr,
  output logic                 o_FrameErr,
  output logic                 o_Break,
  output logic                 o_Overrun
);

  localparam int c_CPB   = SYS_CLOCK / UART_BAUDRATE;
  localparam int c_HALF  = c_CPB / 2;
  localparam int c_CNT_W = $clog2(c_CPB);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CPB - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
  localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rxState_t;

  logic                 r_RxMeta;
  logic                 r_RxSync;
  logic [1:0]           r_Live;
  logic                 r_Armed;
  rxState_t             r_State;
  rxState_t             w_NextState;
  logic [c_CNT_W-1:0]   r_Cnt;
  logic [c_CNT_W-1:0]   w_NextCnt;
  logic [3:0]           r_BitIdx;
  logic [3:0]           w_NextBitIdx;
  logic                 w_Sample;
  logic                 w_Commit;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_ParErr;
  logic                 r_FrameErr;
  logic                 r_AllZero;
  logic                 w_ParBad;
  logic                 w_FrameErrNow;
  logic                 w_BreakNow;
  logic                 w_Load;
  logic                 w_Handshake;

  // Two-flop synchronizer; r_Live marks when r_RxSync holds a real pin sample
  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      r_RxMeta <= 1'b1;
      r_RxSync <= 1'b1;
      r_Live   <= 2'b00;
    end else begin
      r_RxMeta <= i_RxSerial;
      r_RxSync <= r_RxMeta;
      r_Live   <= {r_Live[0], 1'b1};
    end
  end

  // Arm only once the real line has been seen high; a frame ending with a low
  // stop sample disarms so a held-low line (break) yields a single frame
  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Armed <= 1'b0;
    end else if (w_Commit && !r_RxSync) begin
      r_Armed <= 1'b0;
    end else if (r_Live[1] && r_RxSync) begin
      r_Armed <= 1'b1;
    end
  end

  // FSM state, bit-timing counter and bit index registers
  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State  <= ST_IDLE;
      r_Cnt    <= '0;
      r_BitIdx <= 4'd0;
    end else begin
      r_State  <= w_NextState;
      r_Cnt    <= w_NextCnt;
      r_BitIdx <= w_NextBitIdx;
    end
  end

  // Next-state logic: first sample at T0+HALF, then one sample every CPB
  always_comb begin
    w_NextState  = r_State;
    w_NextCnt    = r_Cnt + c_CNT_ONE;
    w_NextBitIdx = r_BitIdx;
    w_Sample     = 1'b0;
    w_Commit     = 1'b0;
    case (r_State)
      ST_IDLE: begin
        w_NextCnt    = '0;
        w_NextBitIdx = 4'd0;
        if (r_Armed && !r_RxSync) begin
          w_NextState = ST_START;
        end
      end
      ST_START: begin
        if (r_Cnt == c_HALF_LAST) begin
          w_NextCnt    = '0;
          w_NextBitIdx = 4'd0;
          w_NextState  = r_RxSync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_Cnt == c_CNT_LAST) begin
          w_Sample  = 1'b1;
          w_NextCnt = '0;
          if (r_BitIdx == c_DATA_LAST) begin
            w_NextBitIdx = 4'd0;
            w_NextState  = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            w_NextBitIdx = r_BitIdx + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (r_Cnt == c_CNT_LAST) begin
          w_Sample     = 1'b1;
          w_NextCnt    = '0;
          w_NextBitIdx = 4'd0;
          w_NextState  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_Cnt == c_CNT_LAST) begin
          w_Sample  = 1'b1;
          w_NextCnt = '0;
          if (r_BitIdx == c_STOP_LAST) begin
            w_NextBitIdx = 4'd0;
            w_NextState  = ST_IDLE;
            w_Commit     = 1'b1;
          end else begin
            w_NextBitIdx = r_BitIdx + 4'd1;
          end
        end
      end
      default: begin
        w_NextState  = ST_IDLE;
        w_NextCnt    = '0;
        w_NextBitIdx = 4'd0;
      end
    endcase
  end

  assign w_ParBad      = (PARITY == 1) ? ~(^r_Shift ^ r_RxSync) : (^r_Shift ^ r_RxSync);
  assign w_FrameErrNow = r_FrameErr | ~r_RxSync;
  // Break needs data, parity and the first stop bit all low
  assign w_BreakNow    = r_AllZero & ((r_BitIdx != 4'd0) | ~r_RxSync);
  assign w_Handshake   = o_RxValid & i_RxReady;
  assign w_Load        = w_Commit & (~o_RxValid | i_RxReady);

  // Frame datapath: LSB-first shift register and per-frame error accumulators
  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Shift    <= '0;
      r_ParErr   <= 1'b0;
      r_FrameErr <= 1'b0;
      r_AllZero  <= 1'b1;
    end else if (r_State == ST_START) begin
      r_ParErr   <= 1'b0;
      r_FrameErr <= 1'b0;
      r_AllZero  <= 1'b1;
    end else if (w_Sample) begin
      case (r_State)
        ST_DATA: begin
          r_Shift <= {r_RxSync, r_Shift[DATA_BITS-1:1]};
          if (r_RxSync) r_AllZero <= 1'b0;
        end
        ST_PAR: begin
          r_ParErr <= w_ParBad;
          if (r_RxSync) r_AllZero <= 1'b0;
        end
        ST_STOP: begin
          if (!r_RxSync) r_FrameErr <= 1'b1;
          if (r_RxSync && (r_BitIdx == 4'd0)) r_AllZero <= 1'b0;
        end
        default: begin
          r_AllZero <= r_AllZero;
        end
      endcase
    end
  end

  // Holding register: load on commit if free or being drained, else flag overrun
  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      o_RxData    <= '0;
      o_RxValid   <= 1'b0;
      o_ParityErr <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_Break     <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      if (w_Load) begin
        o_RxData    <= r_Shift;
        o_RxValid   <= 1'b1;
        o_ParityErr <= (PARITY != 0) & r_ParErr;
        o_FrameErr  <= w_FrameErrNow;
        o_Break     <= w_BreakNow;
      end else if (w_Handshake) begin
        o_RxValid   <= 1'b0;
        o_ParityErr <= 1'b0;
        o_FrameErr  <= 1'b0;
        o_Break     <= 1'b0;
      end
      if (w_Commit && o_RxValid && !i_RxReady) begin
        o_Overrun <= 1'b1;
      end else if (w_Handshake) begin
        o_Overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Directed self-checking bench for uart_rx_frame (8N1, 8E1, 7O2
//            instances at 8 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ser = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] v, pe, fe, brk, ovr;

  logic [11:0] q0[$], q1[$], q2[$];
  int          nTests = 0;
  int          nFail  = 0;
  int          n;
  logic [7:0]  exp20[20];

  always #5 clk = ~clk;

  uart_rx_frame #(.SYS_CLOCK(800), .UART_BAUDRATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
    .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser[0]), .o_RxData(d0), .o_RxValid(v[0]),
    .i_RxReady(rdy[0]), .o_ParityErr(pe[0]), .o_FrameErr(fe[0]), .o_Break(brk[0]), .o_Overrun(ovr[0]));

  uart_rx_frame #(.SYS_CLOCK(800), .UART_BAUDRATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut8e1 (
    .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser[1]), .o_RxData(d1), .o_RxValid(v[1]),
    .i_RxReady(rdy[1]), .o_ParityErr(pe[1]), .o_FrameErr(fe[1]), .o_Break(brk[1]), .o_Overrun(ovr[1]));

  uart_rx_frame #(.SYS_CLOCK(800), .UART_BAUDRATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut7o2 (
    .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser[2]), .o_RxData(d2), .o_RxValid(v[2]),
    .i_RxReady(rdy[2]), .o_ParityErr(pe[2]), .o_FrameErr(fe[2]), .o_Break(brk[2]), .o_Overrun(ovr[2]));

  // Record every accepted frame as {parity, frame, break, data}
  always @(posedge clk) begin
    if (v[0] && rdy[0]) q0.push_back({pe[0], fe[0], brk[0], 1'b0, d0});
    if (v[1] && rdy[1]) q1.push_back({pe[1], fe[1], brk[1], 1'b0, d1});
    if (v[2] && rdy[2]) q2.push_back({pe[2], fe[2], brk[2], 2'b00, d2});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveBit(input int d, input logic b);
    ser[d] = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Caller must be aligned to a falling edge; par: 0 none, 1 odd, 2 even
  task automatic sendFrame(input int d, input logic [8:0] data, input int nData, input int par,
                           input logic flip, input int nStop, input logic stopVal);
    logic p;
    driveBit(d, 1'b0);
    for (int i = 0; i < nData; i++) driveBit(d, data[i]);
    if (par != 0) begin
      p = ^data;
      if (par == 1) p = ~p;
      driveBit(d, p ^ flip);
    end
    for (int i = 0; i < nStop; i++) driveBit(d, stopVal);
    ser[d] = 1'b1;
  endtask

  // flags = {parity, frame, break}
  task automatic popFrame(input int d, input string tag, input logic [8:0] data, input logic [2:0] flags);
    logic [11:0] f;
    int sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    check({tag, " present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (d == 0)      f = q0.pop_front();
      else if (d == 1) f = q1.pop_front();
      else             f = q2.pop_front();
      check({tag, " data"}, 32'(f[8:0]), 32'(data));
      check({tag, " flags"}, 32'(f[11:9]), 32'(flags));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state, checked while reset is held
    #1;
    check("reset valid", 32'(v), 32'd0);
    check("reset data", 32'(d0), 32'd0);
    check("reset flags", 32'({pe, fe, brk, ovr}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Latency: valid at posedge 79 after the start bit is put on the pin
    n = 0;
    fork
      sendFrame(0, 9'h0A3, 8, 0, 1'b0, 1, 1'b1);
      begin
        while (!v[0] && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("latency 8N1", 32'(n), 32'd79);
      end
    join
    repeat (4) @(negedge clk);
    popFrame(0, "latency frame", 9'h0A3, 3'b000);

    // 8N1 back-to-back: ten 0x55 then ten random bytes
    for (int i = 0; i < 20; i++) exp20[i] = (i < 10) ? 8'h55 : 8'($urandom);
    for (int i = 0; i < 20; i++) sendFrame(0, {1'b0, exp20[i]}, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    check("8N1 frame count", 32'(q0.size()), 32'd20);
    for (int i = 0; i < 20; i++) popFrame(0, "8N1 stream", {1'b0, exp20[i]}, 3'b000);

    // 8E1 good and bad parity, 7O2
    sendFrame(1, 9'h0A5, 8, 2, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    popFrame(1, "8E1 good", 9'h0A5, 3'b000);
    sendFrame(1, 9'h0A5, 8, 2, 1'b1, 1, 1'b1);
    repeat (4) @(negedge clk);
    popFrame(1, "8E1 badpar", 9'h0A5, 3'b100);
    sendFrame(2, 9'h03C, 7, 1, 1'b0, 2, 1'b1);
    repeat (4) @(negedge clk);
    popFrame(2, "7O2", 9'h03C, 3'b000);

    // Framing error, then break
    sendFrame(0, 9'h081, 8, 0, 1'b0, 1, 1'b0);
    repeat (4) @(negedge clk);
    popFrame(0, "stop low", 9'h081, 3'b010);
    ser[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    ser[0] = 1'b1;
    repeat (200) @(negedge clk);
    check("break frame count", 32'(q0.size()), 32'd1);
    popFrame(0, "break", 9'h000, 3'b011);

    // Start glitch shorter than half a bit
    ser[0] = 1'b0;
    repeat (2) @(negedge clk);
    ser[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch no frame", 32'(q0.size()), 32'd0);
    sendFrame(0, 9'h012, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    popFrame(0, "after glitch", 9'h012, 3'b000);

    // Overrun
    rdy[0] = 1'b0;
    sendFrame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    sendFrame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr held data", 32'(d0), 32'h11);
    check("ovr valid", 32'(v[0]), 32'd1);
    check("ovr flag", 32'(ovr[0]), 32'd1);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("ovr valid cleared", 32'(v[0]), 32'd0);
    check("ovr flag cleared", 32'(ovr[0]), 32'd0);
    @(negedge clk);
    popFrame(0, "ovr consumed", 9'h011, 3'b000);

    // Handshake in the same cycle as a commit keeps valid with the new frame
    rdy[0] = 1'b0;
    sendFrame(0, 9'h033, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    fork
      sendFrame(0, 9'h044, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1;
        check("hs pre valid", 32'(v[0]), 32'd1);
        check("hs pre data", 32'(d0), 32'h33);
        @(negedge clk);
        rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("hs valid kept", 32'(v[0]), 32'd1);
        check("hs new data", 32'(d0), 32'h44);
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    check("hs hold valid", 32'(v[0]), 32'd1);
    check("hs no overrun", 32'(ovr[0]), 32'd0);
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);
    popFrame(0, "hs old", 9'h033, 3'b000);
    popFrame(0, "hs new", 9'h044, 3'b000);

    // Asynchronous reset during data bit 4, released while the line is low
    rdy[0] = 1'b0;
    sendFrame(0, 9'h077, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    check("pre-reset valid", 32'(v[0]), 32'd1);
    fork
      sendFrame(0, 9'h00F, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (43) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(v[0]), 32'd0);
        check("async rst data", 32'(d0), 32'd0);
        check("async rst flags", 32'({pe[0], fe[0], brk[0], ovr[0]}), 32'd0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (150) @(negedge clk);
    check("no false frame", 32'(v[0]), 32'd0);
    rdy[0] = 1'b1;
    sendFrame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    popFrame(0, "post reset", 9'h05A, 3'b000);
    check("post reset leftovers", 32'(q0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
